// File: rtl/frame_align_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_align_ctrl                                                |
// | Purpose  : Bitslip sequencer that aligns the ADC frame-clock ISERDES word  |
// |            to TARGET, confirms lock and monitors it for loss.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module frame_align_ctrl #(
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CONFIRM_COUNT = 16,
  parameter int         MAX_ATTEMPTS  = 16,
  parameter int         LOSS_COUNT    = 4,
  parameter logic [7:0] TARGET        = 8'b0000_1111
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_data,
  output logic       bitslip,
  output logic       busy,
  output logic       aligned,
  output logic       error,
  output logic [2:0] slip_total
);

  localparam int c_SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int c_CONF_W = $clog2(CONFIRM_COUNT + 1);
  localparam int c_ATT_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam int c_LOSS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [c_SET_W-1:0]  c_SET_LAST  = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CONF_W-1:0] c_CONF_LAST = c_CONF_W'(CONFIRM_COUNT - 1);
  localparam logic [c_ATT_W-1:0]  c_ATT_MAX   = c_ATT_W'(MAX_ATTEMPTS);
  localparam logic [c_LOSS_W-1:0] c_LOSS_LAST = c_LOSS_W'(LOSS_COUNT - 1);

  localparam logic [c_SET_W-1:0]  c_SET_ONE  = c_SET_W'(1);
  localparam logic [c_CONF_W-1:0] c_CONF_ONE = c_CONF_W'(1);
  localparam logic [c_ATT_W-1:0]  c_ATT_ONE  = c_ATT_W'(1);
  localparam logic [c_LOSS_W-1:0] c_LOSS_ONE = c_LOSS_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SLIP    = 3'd3,
    ST_CONFIRM = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  state_t                r_state;
  logic [7:0]            r_frame_q;
  logic [c_SET_W-1:0]    r_settle_cnt;
  logic [c_CONF_W-1:0]   r_conf_cnt;
  logic [c_ATT_W-1:0]    r_attempts;
  logic [c_LOSS_W-1:0]   r_loss_cnt;
  logic                  w_match;

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      r_frame_q <= 8'h00;
    end else begin
      r_frame_q <= frame_data;
    end
  end

  assign w_match = (r_frame_q == TARGET);

  // Outputs are updated on the same edge as the state they decode, so each
  // transition below also sets the flags that belong to its destination.
  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_conf_cnt   <= '0;
      r_attempts   <= '0;
      r_loss_cnt   <= '0;
      bitslip      <= 1'b0;
      busy         <= 1'b0;
      aligned      <= 1'b0;
      error        <= 1'b0;
      slip_total   <= 3'd0;
    end else begin
      bitslip <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FAIL: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_attempts   <= '0;
            slip_total   <= 3'd0;
            busy         <= 1'b1;
            error        <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt == c_SET_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + c_SET_ONE;
          end
        end

        ST_CHECK: begin
          if (w_match) begin
            r_state    <= ST_CONFIRM;
            r_conf_cnt <= '0;
          end else if (r_attempts == c_ATT_MAX) begin
            r_state <= ST_FAIL;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            r_state <= ST_SLIP;
            bitslip <= 1'b1;
          end
        end

        ST_SLIP: begin
          r_state      <= ST_SETTLE;
          r_settle_cnt <= '0;
          r_attempts   <= r_attempts + c_ATT_ONE;
          slip_total   <= slip_total + 3'd1;
        end

        ST_CONFIRM: begin
          if (w_match) begin
            if (r_conf_cnt == c_CONF_LAST) begin
              r_state    <= ST_LOCKED;
              r_loss_cnt <= '0;
              busy       <= 1'b0;
              aligned    <= 1'b1;
            end else begin
              r_conf_cnt <= r_conf_cnt + c_CONF_ONE;
            end
          end else if (r_attempts == c_ATT_MAX) begin
            r_state <= ST_FAIL;
            busy    <= 1'b0;
            error   <= 1'b1;
          end else begin
            // Glitch during confirm: retry without slipping the word.
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_attempts   <= r_attempts + c_ATT_ONE;
          end
        end

        ST_LOCKED: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_attempts   <= '0;
            slip_total   <= 3'd0;
            busy         <= 1'b1;
            aligned      <= 1'b0;
          end else if (w_match) begin
            r_loss_cnt <= '0;
          end else if (r_loss_cnt == c_LOSS_LAST) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_attempts   <= '0;
            r_loss_cnt   <= '0;
            busy         <= 1'b1;
            aligned      <= 1'b0;
          end else begin
            r_loss_cnt <= r_loss_cnt + c_LOSS_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          aligned <= 1'b0;
          error   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_align_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_frame_align_ctrl                                             |
// | Purpose  : Randomized self-checking bench with a rotating ISERDES model.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_frame_align_ctrl;

  localparam int         S   = 4;
  localparam int         C   = 16;
  localparam int         M   = 16;
  localparam logic [7:0] TGT = 8'h0F;

  logic       clk_div = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] frame_data;
  logic       bitslip, busy, aligned, error;
  logic [2:0] slip_total;

  logic [7:0] base    = TGT;
  logic [2:0] rot     = 3'd0;
  logic       inj_en  = 1'b0;
  logic [7:0] inj_val = 8'h00;

  int cyc         = 0;
  int pulse_total = 0;
  int last_pulse  = 0;
  int min_gap     = 1000;
  int n_checks    = 0;
  int n_pass      = 0;

  frame_align_ctrl dut (
    .clk_div    (clk_div),
    .reset      (reset),
    .start      (start),
    .frame_data (frame_data),
    .bitslip    (bitslip),
    .busy       (busy),
    .aligned    (aligned),
    .error      (error),
    .slip_total (slip_total)
  );

  always #5 clk_div = ~clk_div;

  function automatic logic [7:0] rotr8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < (n % 8); i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  // ISERDES model: every bitslip pulse rotates the captured word right by one.
  assign frame_data = inj_en ? inj_val : rotr8(base, int'(rot));

  always @(posedge clk_div) if (bitslip) rot <= rot + 3'd1;

  always @(negedge clk_div) begin
    if (bitslip) begin
      if (pulse_total != 0 && (cyc - last_pulse) < min_gap) min_gap <= cyc - last_pulse;
      last_pulse  <= cyc;
      pulse_total <= pulse_total + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
    cyc++;
  endtask

  task automatic set_pat(input logic [7:0] p);
    base = rotr8(p, (8 - int'(rot)) % 8);
  endtask

  task automatic inject_bad();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    while (v == TGT) v = 8'($urandom_range(0, 255));
    inj_val = v;
    inj_en  = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // sel 0 waits for aligned, sel 1 for error; rel is cycles since t0.
  task automatic wait_sig(input int sel, input int bound, input int t0, output int rel);
    int n;
    n = 0;
    while (((sel == 0) ? aligned : error) !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) $display("FAIL wait_timeout: observed %0d cycles, expected fewer than %0d", n, bound);
    rel = cyc - t0;
  endtask

  task automatic scen_rot(input int k);
    logic [7:0] p, q;
    int ns, t0, p0, rel;
    p  = rotr8(TGT, (8 - k) % 8);
    q  = p;
    ns = 0;
    while (q != TGT && ns < 8) begin
      q = rotr8(q, 1);
      ns++;
    end
    set_pat(p);
    p0 = pulse_total;
    t0 = cyc;
    do_start();
    check("start_clears_total", slip_total, 0);
    wait_sig(0, 200, t0, rel);
    check("lock_cycle", rel, S + C + 2 + ns * (S + 2));
    check("slip_pulses", pulse_total - p0, ns);
    check("slip_total", slip_total, ns % 8);
    check("busy_at_lock", busy, 0);
  endtask

  initial begin
    int rel, t0, p0, g, seen, n;
    logic [2:0] st0;

    repeat (3) tick();
    check("rst_outputs", {27'd0, bitslip, busy, aligned, error, 1'b0}, 0);
    check("rst_slip_total", slip_total, 0);
    reset = 1'b0;
    repeat (2) tick();

    scen_rot(0);
    scen_rot(3);
    for (int i = 0; i < 4; i++) scen_rot(int'($urandom_range(0, 7)));

    // Stuck frame word exhausts every attempt.
    inj_val = 8'h00;
    inj_en  = 1'b1;
    p0 = pulse_total;
    t0 = cyc;
    do_start();
    wait_sig(1, 300, t0, rel);
    check("fail_cycle", rel, S + 1 + M * (S + 2) + 1);
    check("fail_pulses", pulse_total - p0, M);
    check("fail_total", slip_total, M % 8);
    check("fail_busy", busy, 0);
    check("fail_aligned", aligned, 0);
    inj_en = 1'b0;
    tick();
    scen_rot(int'($urandom_range(1, 7)));

    // Short mismatch burst while locked must not drop lock.
    st0 = slip_total;
    for (int i = 0; i < 3; i++) begin
      inject_bad();
      tick();
      check("loss_short_hold", aligned, 1);
    end
    inj_en = 1'b0;
    repeat (3) begin
      tick();
      check("loss_short_after", aligned, 1);
    end

    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      inject_bad();
      tick();
    end
    check("loss_last_hold", aligned, 1);
    inj_en = 1'b0;
    tick();
    check("loss_drop", aligned, 0);
    check("loss_busy", busy, 1);
    check("loss_keep_total", slip_total, st0);
    wait_sig(0, 200, t0, rel);
    check("relock_cycle", rel, 4 + S + C + 2);

    // Single glitch inside the confirm window.
    set_pat(TGT);
    g  = int'($urandom_range(S + 1, S + C));
    p0 = pulse_total;
    t0 = cyc;
    do_start();
    while (cyc - t0 < g) tick();
    inject_bad();
    tick();
    inj_en = 1'b0;
    wait_sig(0, 200, t0, rel);
    check("glitch_lock", rel, g + S + C + 3);
    check("glitch_pulses", pulse_total - p0, 0);
    check("glitch_total", slip_total, 0);

    // start while busy is ignored.
    t0 = cyc;
    do_start();
    repeat (2) tick();
    do_start();
    while (cyc - t0 < 10) tick();
    do_start();
    wait_sig(0, 200, t0, rel);
    check("busy_start_ignored", rel, S + C + 2);

    // Reset during the third SLIP cycle.
    inj_val = 8'h00;
    inj_en  = 1'b1;
    do_start();
    seen = 0;
    n    = 0;
    while (seen < 3 && n < 100) begin
      tick();
      n++;
      if (bitslip === 1'b1) seen++;
    end
    check("slip_reached", bitslip, 1);
    check("pre_rst_total", slip_total, 2);
    #2;
    reset = 1'b1;
    #1;
    check("rst_slip_bitslip", bitslip, 0);
    check("rst_slip_flags", {29'd0, busy, aligned, error}, 0);
    check("rst_slip_total", slip_total, 0);
    @(posedge clk_div);
    cyc++;
    #3;
    reset  = 1'b0;
    inj_en = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", {28'd0, bitslip, busy, aligned, error}, 0);
    scen_rot(int'($urandom_range(0, 7)));

    check("slip_gap_min", (min_gap >= S + 2) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
